instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
RV32I instruction encoder and program loader, the inverse of the control/immediate decode path. Accepts decoded fields over a valid/ready handshake and packs them into a 32-bit instruction word. Writes the word into the instruction-memory write port at an auto-incrementing address. Used by bring-up benches and the boot loader to build programs from field-level descriptions.

Parameters:
n, 32, instruction/data width
DEPTH, 64, instruction-memory words reachable by the write pointer
ADDR_W, 6, write address width (log2 DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  abort current op; clear pointer and count
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
fmt  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 11x illegal (ImmSel coding, plus R)
opcode  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25] (R only)
rd  in  5  destination register
rs1  in  5  source 1
rs2  in  5  source 2
imm  in  n  sign-extended immediate, byte offset for B/J
wr_en  out  1  imem write strobe
wr_addr  out  ADDR_W  imem word address
wr_data  out  n  encoded instruction
count  out  ADDR_W+1  words written since reset/flush
full  out  1  DEPTH words written
err  out  1  one-cycle pulse: illegal fmt or misaligned B/J imm

Behaviour:
- Reset: state IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0.
- FSM states: IDLE, ENC, WR, FULL.
- IDLE: in_ready=1. in_valid&&in_ready at an edge latches all fields; next state ENC.
- ENC: in_ready=0. At the next edge, wr_data <= encoded word; next state WR.
- ENC, illegal fmt or (fmt B/J and imm[0]=1): err=1 for the cycle after ENC, no write, pointer unchanged, return to IDLE.
- WR: wr_en=1 for exactly one cycle, wr_addr=ptr. At the edge, ptr++ and count++. Next state is FULL if ptr was DEPTH-1, else IDLE.
- Latency: handshake edge k -> wr_en high in cycle k+2. Throughput: 1 word per 3 cycles.
- FULL: full=1, in_ready=0, in_valid ignored. Leaves only via flush or rst.
- flush: priority over handshake, in any state. Next cycle is IDLE with ptr=0, count=0, full=0, wr_en=0. An in-flight word is dropped.
- rst: same as flush; also clears wr_data and err.
- Encoding, unused fields ignored:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Out-of-range imm bits are truncated silently; no range error.
- wr_addr holds the last written address while idle. ptr does not wrap; FULL blocks instead.

Decomposition:
- Shared package: format codes (FMT_I..FMT_R), RV32I opcode constants (OP_R=0110011, OP_I=0010011, OP_S=0100011, OP_B=1100011, OP_LUI=0110111, OP_JAL=1101111), FSM state encoding.
- One combinational sub-module, imm_pack: takes fmt and fields, returns the word plus an illegal flag. It mirrors the immediate generator and is unit-testable against it.

Test Plan:
- addi x1,x0,5 (fmt I, op 0010011, f3 000, rd 1, imm 5) -> wr_data=0x00500093, wr_addr=0, wr_en high 2 cycles after handshake, count=1.
- sw x2,8(x1) (fmt S, f3 010, rs1 1, rs2 2, imm 8) then beq x1,x2,-4 (fmt B, imm 0xFFFFFFFC) -> 0x0020A423 at addr 0, 0xFE208EE3 at addr 1.
- lui x5,0x12345 (fmt U, imm 0x12345000) -> 0x123452B7; add x3,x1,x2 (fmt R, funct7 0) -> 0x002081B3; in_ready low for 2 cycles after each handshake.
- fmt 111, then fmt B with imm=3 -> err pulses once each, wr_en stays 0, count unchanged, in_ready returns to 1.
- DEPTH=4: 4 writes -> full=1, in_ready=0; 5th in_valid produces no write; flush -> full=0, count=0, next write at addr 0.
- flush asserted in ENC -> no wr_en follows, IDLE next cycle. rst asserted in WR with in_valid held high -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I field-level encoder: format codes, opcodes,
// FSM states and the latched field bundle.
package instr_encoder_pkg;

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_U = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2,
        ST_FULL = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters the immediate and register fields into an
// RV32I word, the exact inverse of the immediate generator's gather.
module imm_pack
    import instr_encoder_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (f.fmt)
            FMT_R: word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I: word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S: word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B: begin
                word    = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                           f.imm[4:1], f.imm[11], f.opcode};
                // Branch targets are halfword multiples; bit 0 has no slot.
                illegal = f.imm[0];
            end
            FMT_U: word = {f.imm[31:12], f.rd, f.opcode};
            FMT_J: begin
                word    = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                           f.rd, f.opcode};
                illegal = f.imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Field-bundle to instruction-memory loader: accept, encode, write at an
// auto-incrementing address, and stop when the memory window is full.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int n      = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [n-1:0]      imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [n-1:0]      wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

    state_e            state_q, state_d;
    fields_t           fields_q, fields_d;
    logic [n-1:0]      wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_illegal;

    imm_pack u_imm_pack (
        .f       (fields_q),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // Flush wins over a same-cycle handshake, so never advertise ready then.
    assign in_ready = (state_q == ST_IDLE) && !flush;
    assign wr_en    = (state_q == ST_WR);
    assign full     = (state_q == ST_FULL);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign count    = count_q;
    assign err      = err_q;

    always_comb begin
        state_d   = state_q;
        fields_d  = fields_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    fields_d.fmt    = fmt;
                    fields_d.opcode = opcode;
                    fields_d.funct3 = funct3;
                    fields_d.funct7 = funct7;
                    fields_d.rd     = rd;
                    fields_d.rs1    = rs1;
                    fields_d.rs2    = rs2;
                    fields_d.imm    = imm;
                    state_d         = ST_ENC;
                end
            end
            ST_ENC: begin
                if (enc_illegal) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wr_data_d = enc_word;
                    // The write pointer is the low bits of count; count never exceeds DEPTH.
                    wr_addr_d = count_q[ADDR_W-1:0];
                    state_d   = ST_WR;
                end
            end
            ST_WR: begin
                count_d = count_q + 1'b1;
                state_d = (count_q == LAST_SLOT) ? ST_FULL : ST_IDLE;
            end
            ST_FULL: state_d = ST_FULL;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            wr_addr_d = '0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fields_q  <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fields_q  <= fields_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder with a write scoreboard and
// hand-written flush/reset/full sequences (DEPTH reduced to 4).
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        fmt = '0;
    logic [6:0]        opcode = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [31:0]       imm = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    instr_encoder #(.n(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush_first;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        exp_err;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_ptr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
        else $display("ok   %s = %h", nm, act);
    endtask

    function automatic vec_t mk(input logic fl, input logic [2:0] f, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] im, input logic e, input logic [31:0] x,
                                input string nm);
        vec_t v;
        v.flush_first = fl; v.fmt = f; v.op = op; v.f3 = f3; v.f7 = f7;
        v.rd = d; v.rs1 = s1; v.rs2 = s2; v.imm = im;
        v.exp_err = e; v.exp_data = x; v.name = nm;
        return v;
    endfunction

    // Scoreboard: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: wr_en=1 addr=%0d data=%h, required no write",
                         wr_addr, wr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_addr", 32'(wr_addr), e.addr);
                chk("sb_data", wr_data, e.data);
            end
        end
    end

    task automatic drive(input vec_t v);
        fmt = v.fmt; opcode = v.op; funct3 = v.f3; funct7 = v.f7;
        rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
        in_valid = 1'b1;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic send(input vec_t v);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk({v.name, ":ready_wait"}, 32'(in_ready), 32'd1);
        drive(v);
        if (!v.exp_err) sb.push_back('{addr: 32'(exp_ptr), data: v.exp_data});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk({v.name, ":enc_ready"}, 32'(in_ready), 32'd0);
        chk({v.name, ":enc_wr_en"}, 32'(wr_en), 32'd0);
        @(negedge clk);
        chk({v.name, ":wr_en"}, 32'(wr_en), 32'(!v.exp_err));
        chk({v.name, ":err"}, 32'(err), 32'(v.exp_err));
        if (!v.exp_err) exp_ptr++;
        @(negedge clk);
        chk({v.name, ":count"}, 32'(count), 32'(exp_ptr));
        chk({v.name, ":full"}, 32'(full), 32'(exp_ptr == DEPTH));
        chk({v.name, ":ready"}, 32'(in_ready), 32'(exp_ptr != DEPTH));
        chk({v.name, ":err_clear"}, 32'(err), 32'd0);
        if (!v.exp_err) chk({v.name, ":addr_hold"}, 32'(wr_addr), 32'(exp_ptr - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1, FMT_I, OP_I,   3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        0, 32'h00500093, "addi");
        vecs[1]  = mk(1, FMT_S, OP_S,   3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        0, 32'h0020A423, "sw");
        vecs[2]  = mk(0, FMT_B, OP_B,   3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 0, 32'hFE208EE3, "beq");
        vecs[3]  = mk(1, FMT_U, OP_LUI, 3'b000, 7'h00, 5'd5, 5'd7, 5'd9, 32'h12345000, 0, 32'h123452B7, "lui");
        vecs[4]  = mk(0, FMT_R, OP_R,   3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 0, 32'h002081B3, "add");
        vecs[5]  = mk(1, 3'b111, OP_I,  3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        1, 32'h0,        "fmt111");
        vecs[6]  = mk(0, FMT_B, OP_B,   3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,        1, 32'h0,        "b_odd");
        vecs[7]  = mk(0, FMT_J, OP_JAL, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h101,      1, 32'h0,        "j_odd");
        vecs[8]  = mk(0, 3'b110, OP_R,  3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,        1, 32'h0,        "fmt110");
        vecs[9]  = mk(0, FMT_J, OP_JAL, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,        0, 32'h008000EF, "jal_p8");
        vecs[10] = mk(0, FMT_J, OP_JAL, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 0, 32'hFF9FF06F, "jal_m8");
        vecs[11] = mk(0, FMT_I, OP_I,   3'b000, 7'h7F, 5'd1, 5'd0, 5'd31, 32'h00001005, 0, 32'h00500093, "addi_trunc");
        vecs[12] = mk(0, FMT_R, OP_R,   3'b000, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,        0, 32'h402081B3, "sub");

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst:in_ready", 32'(in_ready), 32'd1);
        chk("rst:wr_en",    32'(wr_en),    32'd0);
        chk("rst:wr_addr",  32'(wr_addr),  32'd0);
        chk("rst:wr_data",  wr_data,       32'd0);
        chk("rst:count",    32'(count),    32'd0);
        chk("rst:full",     32'(full),     32'd0);
        chk("rst:err",      32'(err),      32'd0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].flush_first) do_flush();
            send(vecs[i]);
        end

        // Memory window is full: held in_valid must be ignored.
        @(negedge clk);
        drive(vecs[0]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("full:in_ready", 32'(in_ready), 32'd0);
            chk("full:full",     32'(full),     32'd1);
        end
        chk("full:count", 32'(count), 32'd4);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
        chk("unfull:full",     32'(full),     32'd0);
        chk("unfull:count",    32'(count),    32'd0);
        chk("unfull:in_ready", 32'(in_ready), 32'd1);
        send(vecs[0]);

        // Flush while encoding drops the word.
        @(negedge clk);
        drive(vecs[3]);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
        chk("flush_enc:wr_en",    32'(wr_en),    32'd0);
        chk("flush_enc:in_ready", 32'(in_ready), 32'd1);
        chk("flush_enc:count",    32'(count),    32'd0);
        @(negedge clk);
        chk("flush_enc:wr_en2",   32'(wr_en),    32'd0);

        // Reset during the write cycle with in_valid still asserted.
        @(negedge clk);
        drive(vecs[0]);
        sb.push_back('{addr: 32'd0, data: 32'h00500093});
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr:wr_en", 32'(wr_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr:wr_en",    32'(wr_en),    32'd0);
        chk("rst_wr:wr_addr",  32'(wr_addr),  32'd0);
        chk("rst_wr:wr_data",  wr_data,       32'd0);
        chk("rst_wr:count",    32'(count),    32'd0);
        chk("rst_wr:full",     32'(full),     32'd0);
        chk("rst_wr:err",      32'(err),      32'd0);
        chk("rst_wr:in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wr:idle_ready", 32'(in_ready), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
